apb_req_master: RTL and testbench
=================================

# apb_req_master

APB4 initiator converting a simple valid/ready request/response channel into single APB4 transfers. It drives the Master side of an APB link, one outstanding transfer at a time, with wait-state handling, error forwarding and an optional completion timeout. It sits between an on-chip requester (bus bridge, debug module, DMA control path) and an APB4 slave or demux.

## Interface
- AddrWidth, 32, width of `paddr_o` and `req_addr_i`
- DataWidth, 32, width of the read and write data; must be a multiple of 8
- TimeoutCycles, 16, maximum ACCESS-phase cycles; ≥1; used only with the macro in Configuration

Ports:
- clk_i  in  1  clock; all logic is rising-edge
- rst_i  in  1  asynchronous, active-high reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when both valid and ready are high
- req_addr_i  in  AddrWidth  transfer address
- req_write_i  in  1  1 = write, 0 = read
- req_wdata_i  in  DataWidth  write data
- req_strb_i  in  DataWidth/8  write byte strobes
- req_prot_i  in  3  `apb_pkg::prot_t` protection
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when both valid and ready are high
- rsp_rdata_o  out  DataWidth  read data; 0 for writes and for errors
- rsp_err_o  out  1  slave error or timeout
- paddr_o, pprot_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o  out  AddrWidth/3/1/1/1/DataWidth/DataWidth/8  APB4 master outputs
- pready_i, prdata_i, pslverr_i  in  1/DataWidth/1  APB4 slave responses

## Operation
- The FSM has four states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - `req_ready_o`=1.
  - On a handshake, register addr, prot, write, wdata and strb into the APB output registers, then go to SETUP.
  - For reads, `pstrb_o` is forced to 0.
- SETUP: `psel_o`=1, `penable_o`=0; always go to ACCESS.
- ACCESS:
  - `psel_o`=1, `penable_o`=1.
  - On `pready_i`=1, capture `rsp_err_o`=`pslverr_i` and `rsp_rdata_o`: `prdata_i` for an error-free read, otherwise 0. Then go to RESP.
  - While `pready_i`=0, stay in ACCESS.
- RESP:
  - `rsp_valid_o`=1 and `psel_o`=`penable_o`=0.
  - On `rsp_ready_i`=1, go to IDLE.
  - Response data is stable while `rsp_valid_o`=1 and not yet accepted.
- Address, control and write data outputs stay stable from SETUP to the end of ACCESS. In IDLE and RESP they hold their last values; they do not toggle.
- `pready_i`, `prdata_i` and `pslverr_i` are ignored outside ACCESS.
- `req_ready_o` is high only in IDLE, so at most one transfer is outstanding. Requests arriving while busy wait on `req_valid_i`.

## Timing
- Reset values (all outputs): 0. The FSM resets to IDLE; `req_ready_o` goes high on the first cycle after reset deasserts.
- Zero-wait-state transfer:
  - request handshake at cycle 0
  - SETUP at cycle 1
  - ACCESS at cycle 2 with `pready_i`=1
  - `rsp_valid_o` at cycle 3
- Each wait state adds one cycle.
- With `rsp_ready_i` tied high, the minimum request-to-request period is 4 cycles (next handshake at cycle 4).
- Timeout (macro enabled):
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with `pready_i`=0.
  - In the cycle where the count equals TimeoutCycles-1 and `pready_i`=0, the transfer aborts: next state RESP with `rsp_err_o`=1 and `rsp_rdata_o`=0.
  - ACCESS therefore lasts at most TimeoutCycles cycles.
  - `pready_i`=1 in the abort cycle wins, giving a normal completion.
  - The counter is `$clog2(TimeoutCycles+1)` bits wide.
- Reset mid-transfer: `psel_o`, `penable_o`, `rsp_valid_o` and `req_ready_o` drop to 0 immediately (asynchronous). The FSM returns to IDLE and the pending response is discarded.

## Configuration
- Macro: `APB_REQ_MASTER_TIMEOUT_EN`.
- Defined: the timeout counter and abort path are compiled in, with the behaviour given in Timing.
- Undefined: no counter exists, TimeoutCycles is ignored, and ACCESS waits indefinitely for `pready_i`.

## Structure
- `apb_pkg` holds `prot_t`, the `addr_t`/`data_t`/`strb_t` defaults and the FSM state enum `req_master_state_e`.
- The timeout counter is a separate sub-module, `apb_timeout_cnt`, with ports clear, enable, expired and parameter TimeoutCycles. It is instantiated only under the macro.
- The top level holds the FSM, the APB output registers and the response registers.

## Test plan
- Write: addr 0x10, wdata 0xDEADBEEF, strb 0xF, `pready_i`=1 in the first ACCESS cycle -> `psel_o` for 2 cycles, then `rsp_valid_o` at cycle 3 with `rsp_err_o`=0 and `rsp_rdata_o`=0.
- Read: addr 0x20, strb input 0xF, slave returns 0x12345678 after 3 wait states -> `pstrb_o`=0; ACCESS lasts 4 cycles; `rsp_rdata_o`=0x12345678; `rsp_valid_o` at cycle 6.
- Slave error: read with `pslverr_i`=1 and `prdata_i`=0xFFFFFFFF -> `rsp_err_o`=1, `rsp_rdata_o`=0.
- Backpressure: `rsp_ready_i`=0 for 5 cycles while a second request is held valid -> `req_ready_o`=0 and response stable throughout; second SETUP one cycle after IDLE re-entry.
- Timeout (macro on, TimeoutCycles=4): `pready_i` held 0 -> ACCESS exactly 4 cycles, then `rsp_err_o`=1. Same test with `pready_i`=1 in the 4th ACCESS cycle -> normal completion with `rsp_err_o`=0.
- Reset asserted in ACCESS -> `psel_o` and `penable_o` fall to 0 in the same cycle, no response is issued, and `req_ready_o`=1 after release.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB4 types: protection attributes, default bus widths and the request-master FSM states.
package apb_pkg;

    localparam int unsigned AddrWidthDef = 32;
    localparam int unsigned DataWidthDef = 32;
    localparam int unsigned StrbWidthDef = DataWidthDef / 8;
    localparam int unsigned ProtWidth    = 3;

    typedef logic [AddrWidthDef-1:0] addr_t;
    typedef logic [DataWidthDef-1:0] data_t;
    typedef logic [StrbWidthDef-1:0] strb_t;

    // APB4 PPROT bit order: [2] instruction, [1] non-secure, [0] privileged
    typedef struct packed {
        logic instr;
        logic nonsecure;
        logic privileged;
    } prot_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } req_master_state_e;

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase wait-state counter; expired flags the last permitted wait cycle.
// Compiled only when APB_REQ_MASTER_TIMEOUT_EN is defined.
`ifdef APB_REQ_MASTER_TIMEOUT_EN
module apb_timeout_cnt #(
    parameter int unsigned TimeoutCycles = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CntWidth = $clog2(TimeoutCycles + 1);

    logic [CntWidth-1:0] cnt;

    // Saturates at the expiry value so a late pready never sees a wrapped count
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + CntWidth'(1);
        end
    end

    assign expired = (cnt == CntWidth'(TimeoutCycles - 1));

endmodule
`endif

// File: rtl/apb_req_master.sv
// APB4 initiator: turns a valid/ready request channel into single APB transfers, one outstanding.
// Define APB_REQ_MASTER_TIMEOUT_EN to abort ACCESS after TimeoutCycles cycles with an error.
module apb_req_master
    import apb_pkg::*;
#(
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned TimeoutCycles = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [AddrWidth-1:0]   req_addr_i,
    input  logic                   req_write_i,
    input  logic [DataWidth-1:0]   req_wdata_i,
    input  logic [DataWidth/8-1:0] req_strb_i,
    input  prot_t                  req_prot_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [DataWidth-1:0]   rsp_rdata_o,
    output logic                   rsp_err_o,
    output logic [AddrWidth-1:0]   paddr_o,
    output prot_t                  pprot_o,
    output logic                   psel_o,
    output logic                   penable_o,
    output logic                   pwrite_o,
    output logic [DataWidth-1:0]   pwdata_o,
    output logic [DataWidth/8-1:0] pstrb_o,
    input  logic                   pready_i,
    input  logic [DataWidth-1:0]   prdata_i,
    input  logic                   pslverr_i
);

    if (TimeoutCycles == 0 || (DataWidth % 8) != 0) begin : g_param_check
        $error("apb_req_master: TimeoutCycles must be >= 1 and DataWidth a multiple of 8");
    end

    req_master_state_e state;
    logic              req_hs;
    logic              timeout_hit;

    assign req_hs = req_valid_i && req_ready_o;

`ifdef APB_REQ_MASTER_TIMEOUT_EN
    logic tmo_clear;
    logic tmo_enable;
    logic tmo_expired;

    // Cleared during SETUP so the count reads zero in the first ACCESS cycle
    assign tmo_clear   = (state == ST_SETUP);
    assign tmo_enable  = (state == ST_ACCESS) && !pready_i;
    assign timeout_hit = tmo_expired && !pready_i;

    apb_timeout_cnt #(
        .TimeoutCycles(TimeoutCycles)
    ) u_timeout_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clear  (tmo_clear),
        .enable (tmo_enable),
        .expired(tmo_expired)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    // FSM with registered APB and response outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            req_ready_o <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
            paddr_o     <= '0;
            pprot_o     <= '0;
            psel_o      <= 1'b0;
            penable_o   <= 1'b0;
            pwrite_o    <= 1'b0;
            pwdata_o    <= '0;
            pstrb_o     <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    req_ready_o <= 1'b1;
                    if (req_hs) begin
                        paddr_o     <= req_addr_i;
                        pprot_o     <= req_prot_i;
                        pwrite_o    <= req_write_i;
                        pwdata_o    <= req_wdata_i;
                        pstrb_o     <= req_write_i ? req_strb_i : '0;
                        psel_o      <= 1'b1;
                        req_ready_o <= 1'b0;
                        state       <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    penable_o <= 1'b1;
                    state     <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (pready_i || timeout_hit) begin
                        psel_o      <= 1'b0;
                        penable_o   <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        state       <= ST_RESP;
                        // A slave completion in the expiry cycle takes precedence
                        if (pready_i) begin
                            rsp_err_o   <= pslverr_i;
                            rsp_rdata_o <= (!pwrite_o && !pslverr_i) ? prdata_i : '0;
                        end else begin
                            rsp_err_o   <= 1'b1;
                            rsp_rdata_o <= '0;
                        end
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        req_ready_o <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_req_master.sv
// Scoreboard bench for apb_req_master: randomized requests, a behavioural APB slave and a response monitor.
module tb_apb_req_master;
    import apb_pkg::*;

    localparam int unsigned TO = 4;
`ifdef APB_REQ_MASTER_TIMEOUT_EN
    localparam bit TmoOn = 1'b1;
`else
    localparam bit TmoOn = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [31:0] req_addr_i = '0;
    logic        req_write_i = 1'b0;
    logic [31:0] req_wdata_i = '0;
    logic [3:0]  req_strb_i = '0;
    prot_t       req_prot_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic [31:0] paddr_o;
    prot_t       pprot_o;
    logic        psel_o;
    logic        penable_o;
    logic        pwrite_o;
    logic [31:0] pwdata_o;
    logic [3:0]  pstrb_o;
    logic        pready_i;
    logic [31:0] prdata_i;
    logic        pslverr_i;

    apb_req_master #(
        .AddrWidth    (32),
        .DataWidth    (32),
        .TimeoutCycles(TO)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o),
        .req_addr_i (req_addr_i),
        .req_write_i(req_write_i),
        .req_wdata_i(req_wdata_i),
        .req_strb_i (req_strb_i),
        .req_prot_i (req_prot_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o  (rsp_err_o),
        .paddr_o    (paddr_o),
        .pprot_o    (pprot_o),
        .psel_o     (psel_o),
        .penable_o  (penable_o),
        .pwrite_o   (pwrite_o),
        .pwdata_o   (pwdata_o),
        .pstrb_o    (pstrb_o),
        .pready_i   (pready_i),
        .prdata_i   (prdata_i),
        .pslverr_i  (pslverr_i)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // One transfer as the slave will serve it: w wait states, then serr/rdata
    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  strb;
        prot_t       prot;
        int          w;
        logic        serr;
        logic [31:0] rdata;
        bit          chk;
    } plan_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          hs;
    } exp_t;

    plan_t plan_q[$];
    exp_t  exp_q[$];
    int    total = 0;
    int    bad = 0;
    int    rsp_mode = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit times_out(plan_t p);
        return TmoOn && (p.w >= int'(TO));
    endfunction

    function automatic int access_cycles(plan_t p);
        return times_out(p) ? int'(TO) : p.w + 1;
    endfunction

    // Reference: handshake -> SETUP -> ACCESS cycles -> RESP
    function automatic exp_t model(plan_t p, int hs);
        exp_t e;
        e.err   = times_out(p) || p.serr;
        e.rdata = (!p.write && !e.err) ? p.rdata : 32'h0;
        e.lat   = access_cycles(p) + 2;
        e.hs    = hs;
        return e;
    endfunction

    function automatic plan_t mk(logic [31:0] a, logic wr, logic [31:0] wd, logic [3:0] st,
                                 int w, logic serr, logic [31:0] rd);
        plan_t p;
        p.addr = a; p.write = wr; p.wdata = wd; p.strb = st;
        p.prot = prot_t'(3'($urandom));
        p.w = w; p.serr = serr; p.rdata = rd; p.chk = 1'b1;
        return p;
    endfunction

    task automatic send(input plan_t p, input bit expect_rsp, output int hs);
        int n = 0;
        req_valid_i = 1'b1;
        req_addr_i  = p.addr;
        req_write_i = p.write;
        req_wdata_i = p.wdata;
        req_strb_i  = p.strb;
        req_prot_i  = p.prot;
        while (!req_ready_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        hs = cyc;
        check("req_accept", req_ready_o, 1);
        if (req_ready_o) begin
            plan_q.push_back(p);
            if (expect_rsp) exp_q.push_back(model(p, cyc));
        end
        @(negedge clk_i);
        req_valid_i = 1'b0;
        req_addr_i  = $urandom;
        req_write_i = 1'($urandom);
        req_wdata_i = $urandom;
        req_strb_i  = 4'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || plan_q.size() != 0 || rsp_valid_o) && n < 500) begin
            @(negedge clk_i);
            n++;
        end
        check("drain_done", 64'(n < 500), 1);
        @(negedge clk_i);
    endtask

    // Behavioural APB slave: serves plan_q in order and checks the address phase
    initial begin
        bit    active;
        int    k;
        plan_t p;
        active = 0; k = 0;
        pready_i = 1'b0; prdata_i = '0; pslverr_i = 1'b0;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                active = 0;
                pready_i = 1'b0;
            end else if (psel_o && penable_o) begin
                if (!active) begin
                    active = 1; k = 0;
                    check("access_has_plan", 64'(plan_q.size() != 0), 1);
                    if (plan_q.size() != 0) p = plan_q[0];
                    else begin p.chk = 1'b0; p.w = 0; end
                end
                if (p.chk) begin
                    check("apb_ctrl", {paddr_o, pwrite_o, pstrb_o, pprot_o},
                          {p.addr, p.write, (p.write ? p.strb : 4'h0), p.prot});
                    if (p.write) check("apb_wdata", pwdata_o, p.wdata);
                end
                pready_i  = (k == p.w);
                prdata_i  = pready_i ? p.rdata : $urandom;
                pslverr_i = pready_i ? p.serr : 1'($urandom);
                k++;
            end else begin
                if (active) begin
                    if (p.chk) check("access_cycles", k, access_cycles(p));
                    if (plan_q.size() != 0) void'(plan_q.pop_front());
                    active = 0;
                end
                if (psel_o && plan_q.size() != 0 && plan_q[0].chk)
                    check("setup_addr", {paddr_o, pwrite_o}, {plan_q[0].addr, plan_q[0].write});
                pready_i  = 1'($urandom);
                prdata_i  = $urandom;
                pslverr_i = 1'($urandom);
            end
        end
    end

    // Response monitor: pops the scoreboard on each new response, then checks it holds
    initial begin
        bit          seen;
        int          hold;
        exp_t        e;
        logic        held_err;
        logic [31:0] held_rdata;
        seen = 0; hold = 0;
        held_err = 1'b0; held_rdata = '0;
        rsp_ready_i = 1'b0;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                seen = 0;
                rsp_ready_i = 1'b0;
            end else if (rsp_valid_o) begin
                if (!seen) begin
                    seen = 1;
                    hold = (rsp_mode == 2) ? 5 : 0;
                    check("rsp_expected", 64'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("rsp_err", rsp_err_o, e.err);
                        check("rsp_rdata", rsp_rdata_o, e.rdata);
                        check("rsp_latency", cyc - e.hs, e.lat);
                    end
                    held_err = rsp_err_o;
                    held_rdata = rsp_rdata_o;
                end else begin
                    check("rsp_stable", {rsp_err_o, rsp_rdata_o}, {held_err, held_rdata});
                end
                check("req_ready_busy", req_ready_o, 0);
                check("apb_idle_in_resp", {psel_o, penable_o}, 0);
                case (rsp_mode)
                    0: rsp_ready_i = 1'b1;
                    1: rsp_ready_i = ($urandom_range(0, 2) != 0);
                    default: begin
                        if (hold > 0) begin
                            rsp_ready_i = 1'b0;
                            hold--;
                        end else begin
                            rsp_ready_i = 1'b1;
                        end
                    end
                endcase
                if (rsp_ready_i) seen = 0;
            end else begin
                rsp_ready_i = (rsp_mode == 0) ? 1'b1 : 1'($urandom);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        plan_t p;
        int    hs;
        int    prev_hs;
        int    n;
        repeat (3) @(negedge clk_i);
        check("reset_outputs", {req_ready_o, rsp_valid_o, psel_o, penable_o, rsp_err_o},
              5'b0);
        check("reset_paddr", paddr_o, 0);
        check("reset_rdata", rsp_rdata_o, 0);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("ready_after_reset", req_ready_o, 1);

        // Directed: zero-wait write, 3-wait read, slave error
        p = mk(32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'hCAFE0000);
        send(p, 1, hs);
        p = mk(32'h20, 1'b0, 32'h0, 4'hF, 3, 1'b0, 32'h12345678);
        send(p, 1, hs);
        p = mk(32'h24, 1'b0, 32'h0, 4'hF, 1, 1'b1, 32'hFFFFFFFF);
        send(p, 1, hs);
        drain();

        // Back-to-back zero-wait with rsp_ready high: 4-cycle request period
        rsp_mode = 0;
        prev_hs = 0;
        for (int i = 0; i < 3; i++) begin
            p = mk(32'h100 + 32'(i * 4), 1'(i), $urandom, 4'($urandom), 0, 1'b0, $urandom);
            send(p, 1, hs);
            if (i > 0) check("req_period", hs - prev_hs, 4);
            prev_hs = hs;
        end
        drain();

        // Response backpressure with a second request held valid
        rsp_mode = 2;
        p = mk(32'h200, 1'b0, 32'h0, 4'hF, 0, 1'b0, 32'hA5A55A5A);
        send(p, 1, hs);
        p = mk(32'h204, 1'b1, 32'h01020304, 4'h3, 1, 1'b0, 32'h0);
        send(p, 1, hs);
        drain();

`ifdef APB_REQ_MASTER_TIMEOUT_EN
        rsp_mode = 0;
        p = mk(32'h300, 1'b0, 32'h0, 4'hF, 10, 1'b0, 32'h77777777);
        send(p, 1, hs);
        p = mk(32'h304, 1'b0, 32'h0, 4'hF, TO - 1, 1'b0, 32'h55AA55AA);
        send(p, 1, hs);
        drain();
`endif

        // Randomized traffic with random response backpressure
        rsp_mode = 1;
        for (int i = 0; i < 60; i++) begin
            p = mk($urandom, 1'($urandom), $urandom, 4'($urandom),
                   int'($urandom_range(0, TmoOn ? 6 : 4)), ($urandom_range(0, 4) == 0), $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk_i);
            send(p, 1, hs);
        end
        drain();

        // Reset in the middle of ACCESS
        rsp_mode = 0;
        p = mk(32'h400, 1'b0, 32'h0, 4'hF, 20, 1'b0, 32'h0);
        p.chk = 1'b0;
        send(p, 0, hs);
        n = 0;
        while (!(psel_o && penable_o) && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        check("reached_access", {psel_o, penable_o}, 2'b11);
        #2 rst_i = 1'b1;
        #1;
        check("mid_reset_apb", {psel_o, penable_o}, 2'b00);
        check("mid_reset_handshake", {rsp_valid_o, req_ready_o}, 2'b00);
        plan_q.delete();
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("ready_after_mid_reset", req_ready_o, 1);
        repeat (5) @(negedge clk_i);
        check("no_rsp_after_reset", rsp_valid_o, 0);

        // Recovery transfer after the aborted one
        p = mk(32'h500, 1'b0, 32'h0, 4'hF, 2, 1'b0, 32'h0BADF00D);
        send(p, 1, hs);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
